// File: rtl/cdb_arbiter_if.sv
// Result-source and common-data-bus signal bundle for the CDB arbiter.
// The arbiter takes the slave side; functional units and the bench take the master side.
interface cdb_arbiter_if #(
  parameter int NSRC = 4
);
  logic [NSRC-1:0]    src_valid;
  logic [NSRC-1:0]    src_ready;
  logic [NSRC*3-1:0]  src_entry;
  logic [NSRC*32-1:0] src_value;
  logic               flush;
  logic               cdb_write;
  logic [2:0]         cdb_entry;
  logic [31:0]        cdb_value;

  modport master (
    output src_valid, src_entry, src_value, flush,
    input  src_ready, cdb_write, cdb_entry, cdb_value
  );

  modport slave (
    input  src_valid, src_entry, src_value, flush,
    output src_ready, cdb_write, cdb_entry, cdb_value
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one small FIFO per result source, round-robin drain,
// one registered broadcast per cycle, flush squashes everything still queued.
module cdb_arbiter #(
  parameter int NSRC  = 4,
  parameter int DEPTH = 2
) (
  input logic         clk,
  input logic         rst,
  cdb_arbiter_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int RW = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [34:0]     mem    [NSRC][DEPTH];
  logic [PW-1:0]   rd_ptr [NSRC];
  logic [PW-1:0]   wr_ptr [NSRC];
  logic [CW-1:0]   count  [NSRC];
  logic [RW-1:0]   rr;

  logic [NSRC-1:0] ready;
  logic [NSRC-1:0] push;
  logic [NSRC-1:0] pop;
  logic [NSRC-1:0] nonempty;
  logic            grant_vld;
  logic [RW-1:0]   grant_idx;

  logic            cdb_write_q;
  logic [2:0]      cdb_entry_q;
  logic [31:0]     cdb_value_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Ready looks only at stored occupancy, so a full FIFO never passes through.
  always_comb begin
    ready    = '0;
    push     = '0;
    nonempty = '0;
    for (int i = 0; i < NSRC; i++) begin
      ready[i]    = (count[i] != FULL) && !bus.flush;
      push[i]     = bus.src_valid[i] && ready[i];
      nonempty[i] = (count[i] != '0);
    end
  end

  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NSRC; k++) begin
      idx = int'(rr) + k;
      if (idx >= NSRC) idx = idx - NSRC;
      if (!grant_vld && nonempty[idx]) begin
        grant_vld = 1'b1;
        grant_idx = RW'(idx);
      end
    end
    if (bus.flush) grant_vld = 1'b0;
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < NSRC; i++) begin
      pop[i] = grant_vld && (grant_idx == RW'(i));
    end
  end

  // Storage carries no reset; occupancy is governed solely by count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NSRC; i++) begin
      if (push[i]) begin
        mem[i][wr_ptr[i]] <= {bus.src_entry[3*i +: 3], bus.src_value[32*i +: 32]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NSRC; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
      rr          <= '0;
      cdb_write_q <= 1'b0;
      cdb_entry_q <= '0;
      cdb_value_q <= '0;
    end else if (bus.flush) begin
      for (int i = 0; i < NSRC; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
      cdb_write_q <= 1'b0;
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        if (push[i]) wr_ptr[i] <= ptr_inc(wr_ptr[i]);
        if (pop[i])  rd_ptr[i] <= ptr_inc(rd_ptr[i]);
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + 1'b1;
          2'b01:   count[i] <= count[i] - 1'b1;
          default: count[i] <= count[i];
        endcase
      end
      if (grant_vld) begin
        cdb_write_q                <= 1'b1;
        {cdb_entry_q, cdb_value_q} <= mem[grant_idx][rd_ptr[grant_idx]];
        rr <= (grant_idx == RW'(NSRC - 1)) ? '0 : grant_idx + 1'b1;
      end else begin
        cdb_write_q <= 1'b0;
      end
    end
  end

  assign bus.src_ready = ready;
  assign bus.cdb_write = cdb_write_q;
  assign bus.cdb_entry = cdb_entry_q;
  assign bus.cdb_value = cdb_value_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a queue-based reference predicts each broadcast,
// which is compared one cycle later against the registered CDB outputs.
module tb_cdb_arbiter;

  localparam int NSRC  = 4;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic        wr;
    logic [2:0]  entry;
    logic [31:0] value;
  } bc_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cdb_arbiter_if #(.NSRC(NSRC)) bus ();

  cdb_arbiter #(.NSRC(NSRC), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [34:0] mq [NSRC][$];
  bc_t         exp_q [$];
  int          rr_m;
  logic [2:0]  last_entry;
  logic [31:0] last_value;

  int          n_checks;
  int          n_fail;

  logic        obs_write;
  logic [2:0]  obs_entry;
  logic [31:0] obs_value;
  int          gsrc [$];
  int          gent [$];
  logic        ready2_low_seen;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.src_valid = '0;
    bus.src_entry = '0;
    bus.src_value = '0;
    bus.flush     = 1'b0;
  endtask

  task automatic set_src(input int s, input logic [2:0] e, input logic [31:0] v);
    bus.src_valid[s]         = 1'b1;
    bus.src_entry[3*s +: 3]  = e;
    bus.src_value[32*s +: 32] = v;
  endtask

  task automatic clear_model();
    for (int s = 0; s < NSRC; s++) mq[s].delete();
    exp_q.delete();
    rr_m       = 0;
    last_entry = '0;
    last_value = '0;
  endtask

  // Called at posedge+1 with inputs already set; returns at the next posedge+1.
  task automatic cycle();
    logic [NSRC-1:0] rdy;
    bc_t b;
    int  g;
    #1;
    for (int s = 0; s < NSRC; s++) rdy[s] = (mq[s].size() < DEPTH) && !bus.flush;
    check("src_ready", 64'(bus.src_ready), 64'(rdy));
    if (!bus.src_ready[2]) ready2_low_seen = 1'b1;
    b.wr    = 1'b0;
    b.entry = last_entry;
    b.value = last_value;
    if (bus.flush) begin
      for (int s = 0; s < NSRC; s++) mq[s].delete();
    end else begin
      g = -1;
      for (int k = 0; k < NSRC; k++) begin
        int idx;
        idx = (rr_m + k) % NSRC;
        if (g < 0 && mq[idx].size() > 0) g = idx;
      end
      if (g >= 0) begin
        {b.entry, b.value} = mq[g].pop_front();
        b.wr = 1'b1;
        rr_m = (g + 1) % NSRC;
      end
      for (int s = 0; s < NSRC; s++) begin
        if (bus.src_valid[s] && rdy[s]) mq[s].push_back({bus.src_entry[3*s +: 3], bus.src_value[32*s +: 32]});
      end
    end
    exp_q.push_back(b);
    @(posedge clk);
    #1;
    obs_write = bus.cdb_write;
    obs_entry = bus.cdb_entry;
    obs_value = bus.cdb_value;
    b = exp_q.pop_front();
    check("cdb_write", 64'(obs_write), 64'(b.wr));
    check("cdb_entry", 64'(obs_entry), 64'(b.entry));
    check("cdb_value", 64'(obs_value), 64'(b.value));
    last_entry = b.entry;
    last_value = b.value;
    if (obs_write) begin
      gsrc.push_back(int'(obs_value[31:24]));
      gent.push_back(int'(obs_entry));
    end
  endtask

  // Called at posedge+1: asserts reset between edges, holds it across one edge.
  task automatic async_reset();
    #3;
    rst = 1'b0;
    #1;
    check("rst_cdb_write", 64'(bus.cdb_write), 64'd0);
    check("rst_cdb_entry", 64'(bus.cdb_entry), 64'd0);
    check("rst_cdb_value", 64'(bus.cdb_value), 64'd0);
    clear_model();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    ready2_low_seen = 1'b0;
    clear_model();
    clear_inputs();
    rst = 1'b0;
    #1;
    check("init_cdb_write", 64'(bus.cdb_write), 64'd0);
    check("init_cdb_entry", 64'(bus.cdb_entry), 64'd0);
    check("init_cdb_value", 64'(bus.cdb_value), 64'd0);
    check("init_src_ready", 64'(bus.src_ready), 64'hF);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Contention: all four sources at once, round-robin from 0.
    gent.delete();
    for (int s = 0; s < NSRC; s++) set_src(s, 3'(s), {8'(s), 24'h000100 + 24'(s)});
    cycle();
    clear_inputs();
    repeat (5) cycle();
    check("cont_count", 64'(gent.size()), 64'd4);
    for (int i = 0; i < 4 && i < gent.size(); i++) check("cont_entry", 64'(gent[i]), 64'(i));

    // Single push: broadcast two edges after the push, for one cycle only.
    set_src(0, 3'd5, 32'hDEADBEEF);
    cycle();
    clear_inputs();
    check("single_edge1_write", 64'(obs_write), 64'd0);
    cycle();
    check("single_edge2_write", 64'(obs_write), 64'd1);
    check("single_edge2_entry", 64'(obs_entry), 64'd5);
    check("single_edge2_value", 64'(obs_value), 64'hDEADBEEF);
    cycle();
    check("single_edge3_write", 64'(obs_write), 64'd0);

    // Backpressure: source 2 bursts for three cycles against continuous traffic.
    ready2_low_seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      for (int s = 0; s < NSRC; s++) begin
        if (s != 2 || c < 3) set_src(s, 3'((c * NSRC + s) % 8), {8'(s), 24'(c)});
      end
      cycle();
      clear_inputs();
    end
    repeat (12) cycle();
    check("bp_src2_ready_low", 64'(ready2_low_seen), 64'd1);

    // Wrap: alternating single pushes on sources 1 and 3.
    gsrc.delete();
    for (int c = 0; c < 10; c++) begin
      int s;
      s = (c % 2 == 0) ? 1 : 3;
      set_src(s, 3'(c % 8), {8'(s), 24'(c)});
      cycle();
      clear_inputs();
    end
    repeat (3) cycle();
    check("wrap_count", 64'(gsrc.size()), 64'd10);
    for (int i = 0; i < 10 && i < gsrc.size(); i++) check("wrap_src", 64'(gsrc[i]), (i % 2 == 0) ? 64'd1 : 64'd3);

    // Flush: five results queued, then squash with all sources requesting.
    for (int s = 0; s < NSRC; s++) set_src(s, 3'(s + 2), {8'(s), 24'h00A000 + 24'(s)});
    cycle();
    clear_inputs();
    set_src(1, 3'd6, {8'd1, 24'h00B001});
    set_src(2, 3'd7, {8'd2, 24'h00B002});
    cycle();
    clear_inputs();
    for (int s = 0; s < NSRC; s++) set_src(s, 3'(s), {8'(s), 24'h00C000});
    bus.flush = 1'b1;
    cycle();
    clear_inputs();
    check("flush_write", 64'(obs_write), 64'd0);
    #1;
    check("flush_ready_after", 64'(bus.src_ready), 64'hF);
    repeat (4) cycle();

    // Asynchronous reset mid-stream, then a fresh push at entry 7.
    for (int c = 0; c < 2; c++) begin
      for (int s = 0; s < NSRC; s++) set_src(s, 3'(c + s), {8'(s), 24'h00D000 + 24'(c)});
      cycle();
    end
    clear_inputs();
    async_reset();
    #1;
    check("rst_release_ready", 64'(bus.src_ready), 64'hF);
    set_src(0, 3'd7, 32'h00770007);
    cycle();
    clear_inputs();
    check("post_rst_edge1_write", 64'(obs_write), 64'd0);
    cycle();
    check("post_rst_edge2_write", 64'(obs_write), 64'd1);
    check("post_rst_edge2_entry", 64'(obs_entry), 64'd7);
    repeat (3) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
